// File: rtl/cu_cmd_credit_arbiter.sv
// Credit-based command arbiter between the data-read and data-write CU engines.
// One registered grant per cycle: round-robin within a class, alternating between classes.
module cu_cmd_credit_arbiter #(
    parameter int unsigned NUM_READ_REQ  = 8,
    parameter int unsigned NUM_WRITE_REQ = 8,
    parameter int unsigned CREDITS_READ  = 32,
    parameter int unsigned CREDITS_WRITE = 32,
    parameter int unsigned CW            = 7
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enabled,
    input  logic                     cmd_ready,
    input  logic [NUM_READ_REQ-1:0]  read_req,
    input  logic [NUM_WRITE_REQ-1:0] write_req,
    input  logic                     read_credit_return,
    input  logic                     write_credit_return,
    output logic [NUM_READ_REQ-1:0]  read_grant,
    output logic [NUM_WRITE_REQ-1:0] write_grant,
    output logic                     cmd_valid,
    output logic                     cmd_is_write,
    output logic [CW-1:0]            read_credits,
    output logic [CW-1:0]            write_credits,
    output logic                     credit_error,
    output logic                     drained
);

    localparam int unsigned RIW = (NUM_READ_REQ > 1) ? $clog2(NUM_READ_REQ) : 1;
    localparam int unsigned WIW = (NUM_WRITE_REQ > 1) ? $clog2(NUM_WRITE_REQ) : 1;
    localparam logic [CW-1:0] RD_FULL = CW'(CREDITS_READ);
    localparam logic [CW-1:0] WR_FULL = CW'(CREDITS_WRITE);

    typedef enum logic [1:0] {
        ST_DISABLED  = 2'd0,
        ST_ARBITRATE = 2'd1,
        ST_DRAIN     = 2'd2
    } state_e;

    state_e                   state_q, state_d;
    logic [RIW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [WIW-1:0]           wr_ptr_q, wr_ptr_d;
    logic                     prefer_wr_q, prefer_wr_d;
    logic [NUM_READ_REQ-1:0]  rd_gnt_q, rd_gnt_d;
    logic [NUM_WRITE_REQ-1:0] wr_gnt_q, wr_gnt_d;
    logic                     valid_q, valid_d;
    logic                     is_wr_q, is_wr_d;
    logic [CW-1:0]            rd_cnt_q, rd_cnt_d;
    logic [CW-1:0]            wr_cnt_q, wr_cnt_d;
    logic                     err_q, err_d;

    logic [NUM_READ_REQ-1:0]  rd_elig;
    logic [NUM_WRITE_REQ-1:0] wr_elig;
    logic                     rd_found, wr_found;
    logic [RIW-1:0]           rd_idx;
    logic [WIW-1:0]           wr_idx;
    logic                     rd_ok, wr_ok, grant_c, take_wr, rd_take, wr_take;

    // Previous-cycle grant is masked so a requester whose req lags one cycle is not granted twice.
    assign rd_elig = read_req & ~rd_gnt_q;
    assign wr_elig = write_req & ~wr_gnt_q;

    always_comb begin
        logic [31:0] idx;
        rd_found = 1'b0;
        rd_idx   = '0;
        idx      = '0;
        for (int unsigned i = 1; i <= NUM_READ_REQ; i++) begin
            idx = (32'(rd_ptr_q) + i) % NUM_READ_REQ;
            if (!rd_found && rd_elig[RIW'(idx)]) begin
                rd_found = 1'b1;
                rd_idx   = RIW'(idx);
            end
        end
    end

    always_comb begin
        logic [31:0] idx;
        wr_found = 1'b0;
        wr_idx   = '0;
        idx      = '0;
        for (int unsigned i = 1; i <= NUM_WRITE_REQ; i++) begin
            idx = (32'(wr_ptr_q) + i) % NUM_WRITE_REQ;
            if (!wr_found && wr_elig[WIW'(idx)]) begin
                wr_found = 1'b1;
                wr_idx   = WIW'(idx);
            end
        end
    end

    assign rd_ok   = rd_found && (rd_cnt_q != '0);
    assign wr_ok   = wr_found && (wr_cnt_q != '0);
    assign grant_c = (state_q == ST_ARBITRATE) && enabled && cmd_ready && (rd_ok || wr_ok);
    assign take_wr = wr_ok && (!rd_ok || prefer_wr_q);
    assign rd_take = grant_c && !take_wr;
    assign wr_take = grant_c && take_wr;

    always_comb begin
        state_d     = state_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        prefer_wr_d = prefer_wr_q;
        rd_gnt_d    = '0;
        wr_gnt_d    = '0;
        valid_d     = grant_c;
        is_wr_d     = wr_take;
        rd_cnt_d    = rd_cnt_q;
        wr_cnt_d    = wr_cnt_q;
        err_d       = err_q;

        if (rd_take) begin
            rd_gnt_d    = NUM_READ_REQ'(1) << rd_idx;
            rd_ptr_d    = rd_idx;
            prefer_wr_d = 1'b1;
        end
        if (wr_take) begin
            wr_gnt_d    = NUM_WRITE_REQ'(1) << wr_idx;
            wr_ptr_d    = wr_idx;
            prefer_wr_d = 1'b0;
        end

        // A grant and a return on the same class cancel out.
        case ({rd_take, read_credit_return})
            2'b10:   rd_cnt_d = rd_cnt_q - CW'(1);
            2'b01: begin
                if (rd_cnt_q == RD_FULL) err_d = 1'b1;
                else                     rd_cnt_d = rd_cnt_q + CW'(1);
            end
            default: ;
        endcase
        case ({wr_take, write_credit_return})
            2'b10:   wr_cnt_d = wr_cnt_q - CW'(1);
            2'b01: begin
                if (wr_cnt_q == WR_FULL) err_d = 1'b1;
                else                     wr_cnt_d = wr_cnt_q + CW'(1);
            end
            default: ;
        endcase

        unique case (state_q)
            ST_DISABLED:  if (enabled) state_d = ST_ARBITRATE;
            ST_ARBITRATE: if (!enabled) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (enabled)                                      state_d = ST_ARBITRATE;
                else if (rd_cnt_q == RD_FULL && wr_cnt_q == WR_FULL) state_d = ST_DISABLED;
            end
            default:      state_d = ST_DISABLED;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_DISABLED;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            prefer_wr_q <= 1'b0;
            rd_gnt_q    <= '0;
            wr_gnt_q    <= '0;
            valid_q     <= 1'b0;
            is_wr_q     <= 1'b0;
            rd_cnt_q    <= RD_FULL;
            wr_cnt_q    <= WR_FULL;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            prefer_wr_q <= prefer_wr_d;
            rd_gnt_q    <= rd_gnt_d;
            wr_gnt_q    <= wr_gnt_d;
            valid_q     <= valid_d;
            is_wr_q     <= is_wr_d;
            rd_cnt_q    <= rd_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
            err_q       <= err_d;
        end
    end

    assign read_grant    = rd_gnt_q;
    assign write_grant   = wr_gnt_q;
    assign cmd_valid     = valid_q;
    assign cmd_is_write  = is_wr_q;
    assign read_credits  = rd_cnt_q;
    assign write_credits = wr_cnt_q;
    assign credit_error  = err_q;
    assign drained       = (state_q == ST_DISABLED);

endmodule

// File: tb/tb_cu_cmd_credit_arbiter.sv
// Bench for cu_cmd_credit_arbiter: directed scenarios plus random traffic,
// every cycle compared against a behavioural model of grants, credits and mode.
module tb_cu_cmd_credit_arbiter;

    localparam int N    = 8;
    localparam int POOL = 32;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       enabled = 1'b0;
    logic       cmd_ready = 1'b0;
    logic [7:0] read_req = 8'h00;
    logic [7:0] write_req = 8'h00;
    logic       read_credit_return = 1'b0;
    logic       write_credit_return = 1'b0;
    logic [7:0] read_grant, write_grant;
    logic       cmd_valid, cmd_is_write, credit_error, drained;
    logic [6:0] read_credits, write_credits;

    cu_cmd_credit_arbiter dut (
        .clock               (clock),
        .reset               (reset),
        .enabled             (enabled),
        .cmd_ready           (cmd_ready),
        .read_req            (read_req),
        .write_req           (write_req),
        .read_credit_return  (read_credit_return),
        .write_credit_return (write_credit_return),
        .read_grant          (read_grant),
        .write_grant         (write_grant),
        .cmd_valid           (cmd_valid),
        .cmd_is_write        (cmd_is_write),
        .read_credits        (read_credits),
        .write_credits       (write_credits),
        .credit_error        (credit_error),
        .drained             (drained)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode 0 = off, 1 = granting, 2 = waiting for all credits back.
    int m_mode, m_rc, m_wc, m_rptr, m_wptr, m_rg, m_wg;
    bit m_err, m_next_write, m_valid, m_isw;
    int r_sel, w_sel, old_rc, old_wc, jj;
    bit r_ok, w_ok, pick_w, gr, gw;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_mode = 0; m_rc = POOL; m_wc = POOL; m_err = 0;
            m_rptr = 0; m_wptr = 0; m_next_write = 0;
            m_rg = -1; m_wg = -1; m_valid = 0; m_isw = 0;
        end else begin
            r_sel = -1;
            w_sel = -1;
            for (int k = 1; k <= N; k++) begin
                jj = (m_rptr + k) % N;
                if (r_sel < 0 && read_req[3'(jj)] && jj != m_rg) r_sel = jj;
                jj = (m_wptr + k) % N;
                if (w_sel < 0 && write_req[3'(jj)] && jj != m_wg) w_sel = jj;
            end
            r_ok = (r_sel >= 0) && (m_rc > 0);
            w_ok = (w_sel >= 0) && (m_wc > 0);
            gr = 0;
            gw = 0;
            if (m_mode == 1 && enabled && cmd_ready && (r_ok || w_ok)) begin
                pick_w = w_ok && (!r_ok || m_next_write);
                gw = pick_w;
                gr = !pick_w;
            end
            old_rc = m_rc;
            old_wc = m_wc;
            if (gr) m_rc = m_rc - 1;
            if (read_credit_return) begin
                if (m_rc == POOL) m_err = 1; else m_rc = m_rc + 1;
            end
            if (gw) m_wc = m_wc - 1;
            if (write_credit_return) begin
                if (m_wc == POOL) m_err = 1; else m_wc = m_wc + 1;
            end
            m_valid = gr || gw;
            m_isw   = gw;
            m_rg    = gr ? r_sel : -1;
            m_wg    = gw ? w_sel : -1;
            if (gr) begin m_rptr = r_sel; m_next_write = 1; end
            if (gw) begin m_wptr = w_sel; m_next_write = 0; end
            case (m_mode)
                0: if (enabled) m_mode = 1;
                1: if (!enabled) m_mode = 2;
                default: begin
                    if (enabled) m_mode = 1;
                    else if (old_rc == POOL && old_wc == POOL) m_mode = 0;
                end
            endcase
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            check("read_grant",    32'(read_grant),    (m_rg < 0) ? 32'd0 : (32'd1 << m_rg));
            check("write_grant",   32'(write_grant),   (m_wg < 0) ? 32'd0 : (32'd1 << m_wg));
            check("cmd_valid",     32'(cmd_valid),     32'(m_valid));
            check("cmd_is_write",  32'(cmd_is_write),  32'(m_isw));
            check("read_credits",  32'(read_credits),  32'(m_rc));
            check("write_credits", 32'(write_credits), 32'(m_wc));
            check("credit_error",  32'(credit_error),  32'(m_err));
            check("drained",       32'(drained),       32'(m_mode == 0));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    int n;

    initial begin
        #1 reset = 1'b1;
        chk_en = 1'b1;
        tick(2);
        @(negedge clock);
        check("rst_read_credits",  32'(read_credits),  32'd32);
        check("rst_write_credits", 32'(write_credits), 32'd32);
        check("rst_drained",       32'(drained),       32'd1);
        check("rst_cmd_valid",     32'(cmd_valid),     32'd0);
        tick(1);
        reset = 1'b0;

        // Single read command from requester 0.
        enabled = 1'b1;
        tick(1);
        read_req = 8'h01;
        cmd_ready = 1'b1;
        tick(1);
        read_req = 8'h00;
        @(negedge clock);
        check("single_grant",   32'(read_grant),   32'h01);
        check("single_credits", 32'(read_credits), 32'd31);
        tick(3);
        @(negedge clock);
        check("single_no_second", 32'(cmd_valid), 32'd0);

        // Refill, then saturate both classes for 40 cycles.
        tick(1);
        read_credit_return = 1'b1;
        tick(1);
        read_credit_return = 1'b0;
        read_req = 8'hFF;
        write_req = 8'hFF;
        tick(40);
        read_req = 8'h00;
        write_req = 8'h00;
        @(negedge clock);
        check("alt_read_credits",  32'(read_credits),  32'd12);
        check("alt_write_credits", 32'(write_credits), 32'd12);
        tick(1);
        read_credit_return = 1'b1;
        write_credit_return = 1'b1;
        tick(20);
        read_credit_return = 1'b0;
        write_credit_return = 1'b0;

        // Exhaust the read pool, then one return buys exactly one more grant.
        read_req = 8'hFF;
        n = 0;
        repeat (70) begin @(negedge clock); n += int'(cmd_valid); end
        check("exhaust_grants",  32'(n),            32'd32);
        check("exhaust_credits", 32'(read_credits), 32'd0);
        tick(1);
        read_credit_return = 1'b1;
        tick(1);
        read_credit_return = 1'b0;
        n = 0;
        repeat (5) begin @(negedge clock); n += int'(cmd_valid); end
        check("one_more_grant", 32'(n), 32'd1);
        tick(1);
        read_req = 8'h00;
        read_credit_return = 1'b1;
        tick(32);
        read_credit_return = 1'b0;

        // Back-pressure holds grants and credits.
        read_req = 8'hFF;
        cmd_ready = 1'b0;
        n = 0;
        repeat (6) begin @(negedge clock); n += int'(cmd_valid); end
        check("bp_no_grants", 32'(n),            32'd0);
        check("bp_credits",   32'(read_credits), 32'd32);
        tick(1);
        cmd_ready = 1'b1;
        tick(1);
        read_req = 8'h00;
        @(negedge clock);
        check("bp_release_grant",   32'(cmd_valid),    32'd1);
        check("bp_release_credits", 32'(read_credits), 32'd31);

        // Grant and return in the same cycle leave the count alone.
        tick(1);
        read_req = 8'h10;
        read_credit_return = 1'b1;
        tick(1);
        read_req = 8'h00;
        read_credit_return = 1'b0;
        @(negedge clock);
        check("same_cycle_grant",   32'(read_grant),   32'h10);
        check("same_cycle_credits", 32'(read_credits), 32'd31);
        tick(1);
        read_credit_return = 1'b1;
        tick(1);
        read_credit_return = 1'b0;
        tick(1);
        read_credit_return = 1'b1;
        tick(1);
        read_credit_return = 1'b0;
        @(negedge clock);
        check("overflow_error",   32'(credit_error), 32'd1);
        check("overflow_credits", 32'(read_credits), 32'd32);
        tick(5);
        @(negedge clock);
        check("error_sticky", 32'(credit_error), 32'd1);

        // Drain with three reads outstanding.
        tick(1);
        read_req = 8'h07;
        tick(3);
        read_req = 8'h00;
        enabled = 1'b0;
        tick(1);
        n = 0;
        repeat (4) begin @(negedge clock); n += int'(cmd_valid); end
        check("drain_no_grants", 32'(n),       32'd0);
        check("drain_busy",      32'(drained), 32'd0);
        tick(1);
        read_credit_return = 1'b1;
        tick(3);
        read_credit_return = 1'b0;
        @(negedge clock);
        check("drain_last_return", 32'(drained), 32'd0);
        tick(1);
        @(negedge clock);
        check("drain_done", 32'(drained), 32'd1);

        // Reset while draining.
        tick(1);
        enabled = 1'b1;
        read_req = 8'h07;
        tick(3);
        enabled = 1'b0;
        read_req = 8'h00;
        tick(2);
        @(negedge clock);
        check("mid_drain_busy", 32'(drained), 32'd0);
        tick(1);
        reset = 1'b1;
        #1;
        check("mid_reset_rc",      32'(read_credits),  32'd32);
        check("mid_reset_wc",      32'(write_credits), 32'd32);
        check("mid_reset_drained", 32'(drained),       32'd1);
        check("mid_reset_error",   32'(credit_error),  32'd0);
        tick(2);
        reset = 1'b0;

        // Random traffic against the model.
        for (int c = 0; c < 2000; c++) begin
            tick(1);
            reset = ($urandom_range(0, 499) == 0);
            enabled = ($urandom_range(0, 19) != 0);
            cmd_ready = ($urandom_range(0, 3) != 0);
            read_req = 8'($urandom);
            write_req = 8'($urandom);
            read_credit_return  = (m_rc < POOL && $urandom_range(0, 2) == 0) || ($urandom_range(0, 299) == 0);
            write_credit_return = (m_wc < POOL && $urandom_range(0, 2) == 0) || ($urandom_range(0, 299) == 0);
        end
        tick(1);
        reset = 1'b0;
        read_req = 8'h00;
        write_req = 8'h00;
        read_credit_return = 1'b0;
        write_credit_return = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cu_cmd_credit_arbiter.md
Name: cu_cmd_credit_arbiter

Overview:
- Shares PSL command credits between the data-read and data-write compute-unit engines.
- Keeps a separate credit pool per class (read/write).
- Grants at most one command per cycle, round-robin within each class and alternating between classes.
- Sits between the CU engines and the AFU-control read/write command buffers; also sequences enable/drain so the CU control can tell when all commands have retired.

Parameters:
NUM_READ_REQ, 8, number of data-read CU requesters
NUM_WRITE_REQ, 8, number of data-write CU requesters
CREDITS_READ, 32, read credit pool size (1..63)
CREDITS_WRITE, 32, write credit pool size (1..63); CREDITS_READ+CREDITS_WRITE <= 64
CW, 7, credit counter width ($clog2(max pool)+1)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
enabled  in  1  level; 1 = arbitrate, 0 = stop granting and drain
cmd_ready  in  1  downstream command buffer can accept a command this cycle
read_req  in  NUM_READ_REQ  level per requester; high = has a pending read command
write_req  in  NUM_WRITE_REQ  level per requester; high = has a pending write command
read_credit_return  in  1  pulse; one read response retired
write_credit_return  in  1  pulse; one write response retired
read_grant  out  NUM_READ_REQ  registered one-hot grant pulse
write_grant  out  NUM_WRITE_REQ  registered one-hot grant pulse
cmd_valid  out  1  registered; high when any grant is high
cmd_is_write  out  1  registered; class of the current grant
read_credits  out  CW  current free read credits
write_credits  out  CW  current free write credits
credit_error  out  1  sticky; credit return while pool already full
drained  out  1  high in DISABLED state

Behaviour:
- Reset (async, active-high) values:
  - grants = 0, cmd_valid = 0, cmd_is_write = 0
  - read_credits = CREDITS_READ, write_credits = CREDITS_WRITE
  - credit_error = 0, drained = 1
  - state = DISABLED, both round-robin pointers = 0, class toggle = read-first
- States:
  - DISABLED: enabled=1 -> ARBITRATE.
  - ARBITRATE: enabled=0 -> DRAIN.
  - DRAIN: when both pools are full -> DISABLED. enabled=1 while in DRAIN -> ARBITRATE immediately.
- Grants are issued only in ARBITRATE.
- Decision in cycle N is combinational on that cycle's inputs; grant, cmd_valid and cmd_is_write appear registered in cycle N+1 as a single-cycle pulse. Latency is 1.
- Eligibility:
  - A requester is eligible if its req is high and it was not granted in the previous cycle. This previous-grant mask prevents double-granting a single-command requester whose req has not yet dropped.
  - The read class is eligible if any read requester is eligible and read_credits > 0; likewise for write.
- A grant is made only if cmd_ready=1 and at least one class is eligible.
- Class choice:
  - If both classes are eligible, pick the class opposite the last granted class.
  - If only one is eligible, pick it.
  - The toggle updates only on a grant.
- Within a class: round-robin starting at pointer+1 mod N. After a grant the pointer = granted index. The other class's pointer is unchanged.
- Credits:
  - A grant decrements its class counter in the same cycle the decision is made, so the counter value is visible together with the registered grant.
  - A return pulse increments its class counter.
  - Grant and return in the same cycle on the same class: net unchanged.
  - A return when the counter is already at its pool size: counter unchanged, credit_error set, held until reset.
  - A counter never goes below 0; a class at 0 credits is ineligible.
- enabled dropping while a grant is being registered: that grant still completes (it was decided in ARBITRATE); no further grants.
- Credit returns are accepted in every state.
- drained = 1 only in DISABLED.

Test Plan:
- Reset, then enabled=1, read_req[0]=1 for one command (dropped the cycle after its grant), cmd_ready=1 -> exactly one read_grant[0] pulse, 1 cycle after the request; read_credits 32->31; no second grant.
- read_req=8'hFF and write_req=8'hFF held, 40 cycles, no returns -> grants alternate R,W,R,W; read indices 1,2,..7,0,...; both counters reach 0 after 32 grants each (64 cycles total is capped at 40 here: 20 each, counters 12/12).
- read_req held, no returns -> exactly 32 read grants, then cmd_valid=0 with read_credits=0. One read_credit_return -> exactly one further grant.
- cmd_ready=0 for 5 cycles with requests pending -> no grants and counters unchanged. cmd_ready=1 -> grant on the next cycle.
- Grant and read_credit_return in the same cycle -> read_credits unchanged. A return with read_credits=32 -> credit_error=1, counter stays 32, error persists until reset.
- 3 read grants outstanding, enabled=0 -> no grants. drained rises 1 cycle after the 3rd return. Assert reset mid-DRAIN -> counters back to 32/32, drained=1 immediately.
